// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Optional multiply early-out is enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  // Operand conditioning for the accept cycle.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // Shift-add step: carry out of the upper-half add lands in the top bit.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? mcand_q : '0)};
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: partial remainder needs WIDTH+1 bits after the shift.
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_acc;
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opb_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - opb_q;
  assign div_acc = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem, fix_dz_hi;
  assign fix_prod  = quo_neg_q ? -acc_q : acc_q;
  assign fix_quo   = quo_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign fix_rem   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  // Divide-by-zero leaves |a| untouched in the low half; re-signing restores a.
  assign fix_dz_hi = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
  logic [CW-1:0] resid;
  assign resid = cnt_q - CW'(1);
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dz_pend_d = dz_pend_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d  = op[1];
          quo_neg_d = a_neg ^ b_neg;
          rem_neg_d = op[1] & a_neg;
          dz_pend_d = op[1] & (b == '0);
          mcand_d   = mag_a;
          opb_d     = mag_b;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
          cnt_d     = CW'(WIDTH);
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          if (!dz_pend_q) acc_d = div_acc;
        end else begin
          acc_d = mul_acc;
          opb_d = opb_q >> 1;
        end
        if (cnt_q == CW'(1)) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && opb_q[WIDTH-1:1] == '0) begin
          acc_d   = mul_acc >> resid;
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        if (is_div_q) begin
          if (dz_pend_q) begin
            hi_d  = fix_dz_hi;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = fix_rem;
            lo_d = fix_quo;
          end
        end else begin
          hi_d = fix_prod[2*WIDTH-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
  end

  // NOTE: datapath flops are reset too, so an async reset mid-op leaves no stale operand state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_pend_q <= 1'b0;
      mcand_q   <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_pend_q <= dz_pend_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stall       = busy & (start | hilo_rd | hi_we | lo_we);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO/flag/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0, hilo_rd = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero, stall;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bv);
    int lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] m;
    if (!o[1]) begin
      m = (!o[0] && bv[31]) ? -bv : bv;
      lat = 2;
      for (int i = 0; i < 32; i++) if (m[i]) lat = i + 2;
    end
`endif
    return lat;
  endfunction

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("div_by_zero", div_by_zero, e.dz);
          check("latency", cyc - e.start_edge, e.lat);
        end
      end
      if (div_by_zero && !done) check("dz_without_done", 1, 0);
    end
  end

  // Called at a negedge; waits (bounded) for IDLE, then presents start for one cycle.
  task automatic drive_start(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                             output int start_edge);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
    op = o; a = av; b = bv; start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    int se;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = exp_lat(o, bv);
    se = cyc + 1;
    e.start_edge = se;
    sb.push_back(e);
    drive_start(o, av, bv, se);
    sb[sb.size()-1].start_edge = se;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] hi_prev, lo_prev;
    int se;

    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ops, issued back-to-back (next start lands in the done cycle).
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(OP_MULT,  32'h1234_5678, 32'd0,         32'h0000_0000, 32'h0000_0000, 1'b0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    issue(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    issue(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    drain();

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", hi, 32'h0000_1234);
    lo_we = 1'b1; wdata = 32'h0000_ABCD;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", lo, 32'h0000_ABCD);

    // Mid-op hazards: stall, ignored second start, ignored MT write.
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (3) @(negedge clk);
    hilo_rd = 1'b1;
    #1 check("stall_hilo_rd", stall, 1);
    @(negedge clk);
    hilo_rd = 1'b0;
    op = OP_MULTU; a = 32'd3; b = 32'd3; start = 1'b1;
    #1 check("stall_start", stall, 1);
    repeat (2) @(negedge clk);
    start = 1'b0;
    #1 check("stall_idle_inputs", stall, 0);
    hi_prev = hi;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    #1 check("stall_hi_we", stall, 1);
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_busy_ignored", hi, hi_prev);
    drain();

    // Flush at edge k+10.
    hi_prev = hi; lo_prev = lo;
    drive_start(OP_MULTU, 32'd5, 32'd6, se);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hi", hi, hi_prev);
    check("flush_lo", lo, lo_prev);
    repeat (40) @(negedge clk);

    // Flush beats start in the same cycle.
    op = OP_MULTU; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_over_start", busy, 0);
    repeat (40) @(negedge clk);

    // Async reset mid-RUN.
    drive_start(OP_MULTU, 32'd9, 32'd9, se);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the integer multiply/divide path of the execute stage. Handles MULT/MULTU/DIV/DIVU with an iterative shift-add multiplier and a restoring divider, owns the architectural HI/LO registers, and raises a pipeline stall whenever a HI/LO access or new op collides with an operation in flight. The ALU decoder selects the op; this block supplies the HI/LO values that MFHI/MFLO return.

## Interface
- WIDTH, 32: operand and HI/LO width; iteration count per op.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin an op; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a, b  in  WIDTH  rs and rt operands; a = multiplicand/dividend, b = multiplier/divisor.
- flush  in  1  abort any op in flight.
- hilo_rd  in  1  EX stage is executing MFHI/MFLO.
- hi_we, lo_we  in  1  MTHI/MTLO write strobes.
- wdata  in  WIDTH  MTHI/MTLO data.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  op in flight (RUN or FIX).
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  qualified by done; divisor was zero.
- stall  out  1  combinational: busy & (start | hilo_rd | hi_we | lo_we).

## Operation
- FSM: IDLE, RUN, FIX.
- IDLE: on start=1, latch |a|, |b| (magnitudes for signed ops, raw for unsigned), result-sign bits (MULT: a^b; DIV: quotient a^b, remainder a), op; clear 2*WIDTH accumulator; counter = WIDTH; go RUN.
- RUN: one iteration per cycle; MUL: if multiplier LSB, add multiplicand to upper half; shift right. DIV: shift remainder left, trial-subtract divisor, set quotient bit if non-negative. Counter decrements; at count 1 go FIX.
- FIX: negate the 2*WIDTH product or quotient/remainder per latched sign; write hi/lo; pulse done; go IDLE.
- MUL result: hi = product[2W-1:W], lo = product[W-1:0].
- DIV result: lo = quotient, hi = remainder (sign follows dividend).
- Divide by zero: skips iteration math; at FIX hi = a, lo = all ones, div_by_zero = 1 with done.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0, no flag.
- start while busy: ignored; caller holds it (stall asserted).
- hi_we/lo_we: write wdata to hi/lo in IDLE; ignored while busy (stall holds them). Write coinciding with an accepted start takes effect; the op result overwrites later.
- flush: any state -> IDLE next edge; hi/lo unchanged; no done; flush wins over start in the same cycle.
- Reset: hi = lo = 0, busy = done = div_by_zero = 0, state IDLE, counter 0; async, mid-op aborts with no result.

## Timing
- start accepted at edge k: busy = 1 after edge k.
- RUN occupies edges k+1 .. k+WIDTH; FIX result written at edge k+WIDTH+1.
- done and div_by_zero high for exactly the cycle after edge k+WIDTH+1; busy low in that same cycle.
- Fixed latency WIDTH+1 edges start-to-done (33 for WIDTH=32), both op classes, divide-by-zero included.
- Back-to-back: start may be accepted in the done cycle.
- hi/lo stable except on the FIX edge or an accepted MT write.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in RUN for MULT/MULTU, if the remaining multiplier bits are all zero, jump to FIX next edge, aligning the product with a residual shift equal to the remaining count; latency = (index of highest set multiplier bit + 1) + 1 edges, minimum 2 (multiplier zero). Divides unaffected.
- Not defined: all ops take the fixed WIDTH+1 latency.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after start (macro off).
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with macro on, b=7 gives done 4 edges after start.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 only in done cycle; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Mid-op: hilo_rd=1 -> stall=1; second start ignored; flush at edge k+10 -> busy=0 next cycle, hi/lo unchanged, no done.
- rst_n low mid-RUN -> hi, lo, busy, done zero immediately, without waiting for a clock edge; MTHI 0x1234 in IDLE -> hi=0x1234 next edge.
